// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_rx_state_t;

  localparam logic [31:0] UART_CLKS_PER_BIT_9600 = 32'h28B0;
  localparam int          UART_DATA_BITS         = 8;

endpackage

// File: rtl/uart_receive_if.sv
// Received-byte output bundle: byte, strobes and busy flag.
interface uart_receive_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      frame_error;
  logic                      busy;

  modport master (output data, output valid, output frame_error, output busy);
  modport slave  (input  data, input  valid, input  frame_error, input  busy);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Latency: 2 cycles.
// Backpressure: none, free-running.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      meta <= RESET_VALUE;
      dout <= RESET_VALUE;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver, LSB first, centre-of-bit sampling.
// Latency: valid ~2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after start edge.
// Backpressure: none; valid/frame_error are single-cycle strobes, consumer must keep up.
module uart_receive
  import uart_pkg::*;
#(
  parameter logic [31:0] CLKS_PER_BIT = UART_CLKS_PER_BIT_9600,
  parameter int          DATA_BITS    = UART_DATA_BITS
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           UART_RX,
  uart_receive_if.master rx_out
);

  localparam logic [31:0] HALF_BIT = (CLKS_PER_BIT >> 1) - 32'd1;
  localparam logic [31:0] FULL_BIT = CLKS_PER_BIT - 32'd1;
  localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t           state, state_next;
  logic [31:0]              bit_cnt, bit_cnt_next;
  logic [2:0]               bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0]     shift_reg, shift_next;
  logic [DATA_BITS-1:0]     data_q, data_next;
  logic                     valid_q, valid_next;
  logic                     ferr_q, ferr_next;

  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .din   (UART_RX),
    .dout  (rx_s)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      data_q    <= data_next;
      valid_q   <= valid_next;
      ferr_q    <= ferr_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt + 32'd1;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    data_next    = data_q;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;

    case (state)
      IDLE: begin
        bit_cnt_next = '0;
        if (!rx_s) state_next = START;
      end

      // A start bit that is high again at its centre was only a glitch.
      START: begin
        if (bit_cnt == HALF_BIT) begin
          bit_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (bit_cnt == FULL_BIT) begin
          bit_cnt_next = '0;
          shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
          if (bit_idx == LAST_IDX) state_next   = STOP;
          else                     bit_idx_next = bit_idx + 3'd1;
        end
      end

      STOP: begin
        if (bit_cnt == FULL_BIT) begin
          bit_cnt_next = '0;
          if (rx_s) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end

      // Hold off until the line recovers so a break cannot spawn frames.
      WAIT_HIGH: begin
        bit_cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end

      default: begin
        bit_cnt_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

  assign rx_out.data        = data_q;
  assign rx_out.valid       = valid_q;
  assign rx_out.frame_error = ferr_q;
  assign rx_out.busy        = (state != IDLE);

endmodule
